video_timing_gen: RTL

Parametrised raster timing generator. Produces blanking, sync, data-enable, pixel coordinates and frame/line markers for any progressive video mode, replacing the fixed 800x525 sync counter. It sits between the pixel clock domain root and the pixel sources (test pattern, font, scope) feeding the TMDS video encoder. It adds clock-enable gating, programmable sync polarity, and a matched delay pipeline that aligns syncs with downstream pixel latency.

---
 rtl/video_pkg.sv | 48 ++++
 rtl/video_delay_line.sv | 35 +++
 rtl/video_timing_gen.sv | 110 +++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared video timing types and standard mode tables.
package video_pkg;

  // One complete progressive raster mode description
  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
    bit hs_pol;
    bit vs_pol;
  } video_timing_t;

  // Signals that travel together through the alignment delay line
  typedef struct packed {
    logic blank;
    logic de;
    logic hsync;
    logic vsync;
    logic line_start;
    logic frame_start;
  } sync_bundle_t;

  localparam int SYNC_BUNDLE_W = $bits(sync_bundle_t);

  localparam video_timing_t VT_640X480_60 = '{
    h_active: 640,  h_fp: 16,  h_sync: 96,  h_bp: 48,
    v_active: 480,  v_fp: 10,  v_sync: 2,   v_bp: 33,
    hs_pol: 1'b0,   vs_pol: 1'b0
  };

  localparam video_timing_t VT_800X600_60 = '{
    h_active: 800,  h_fp: 40,  h_sync: 128, h_bp: 88,
    v_active: 600,  v_fp: 1,   v_sync: 4,   v_bp: 23,
    hs_pol: 1'b1,   vs_pol: 1'b1
  };

  localparam video_timing_t VT_1280X720_60 = '{
    h_active: 1280, h_fp: 110, h_sync: 40,  h_bp: 220,
    v_active: 720,  v_fp: 5,   v_sync: 5,   v_bp: 20,
    hs_pol: 1'b1,   vs_pol: 1'b1
  };

endpackage

// File: rtl/video_delay_line.sv
// Enable-gated shift register with synchronous reset to a fixed value.
// DEPTH=0 degenerates to a plain wire.
module video_delay_line #(
  parameter int             W         = 1,
  parameter int             DEPTH     = 0,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, reset, en};
    assign dout = din;
  end else begin : g_sr
    logic [DEPTH-1:0][W-1:0] sr;

    // Shift one stage per enabled cycle; reset flushes every stage
    always_ff @(posedge clk) begin
      if (reset) begin
        sr <= {DEPTH{RESET_VAL}};
      end else if (en) begin
        sr[0] <= din;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign dout = sr[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised progressive raster timing generator. x/y are registered
// counter copies; the sync bundle is registered and then delayed by PIPE
// more stages so pixel sources can fetch PIPE cycles ahead.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int PIPE     = 0,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          blank,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;

  localparam sync_bundle_t SYNC_RST = '{
    blank: 1'b1, de: 1'b0, hsync: ~HS_POL, vsync: ~VS_POL,
    line_start: 1'b0, frame_start: 1'b0
  };

  if ((2**CW) < H_TOTAL || (2**CW) < V_TOTAL) begin : g_err_cw
    $error("video_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_err_zero
    $error("video_timing_gen: porch and sync widths must be non-zero");
  end
  if (PIPE < 0) begin : g_err_pipe
    $error("video_timing_gen: PIPE must be non-negative");
  end

  logic [CW-1:0] hcnt, vcnt;
  sync_bundle_t  dec, dec_q, sync_o;

  // Decode the sync bundle from the current counter position
  always_comb begin
    dec             = SYNC_RST;
    dec.blank       = (hcnt >= CW'(H_ACTIVE)) || (vcnt >= CW'(V_ACTIVE));
    dec.de          = ~dec.blank;
    dec.hsync       = (hcnt >= CW'(HS_BEG) && hcnt < CW'(HS_END)) ? HS_POL : ~HS_POL;
    dec.vsync       = (vcnt >= CW'(VS_BEG) && vcnt < CW'(VS_END)) ? VS_POL : ~VS_POL;
    dec.line_start  = (hcnt == '0);
    dec.frame_start = (hcnt == '0) && (vcnt == '0);
  end

  // Raster counters plus registered coordinate and sync-bundle outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt  <= '0;
      vcnt  <= '0;
      x     <= '0;
      y     <= '0;
      dec_q <= SYNC_RST;
    end else if (en) begin
      x     <= hcnt;
      y     <= vcnt;
      dec_q <= dec;
      if (hcnt == CW'(H_TOTAL - 1)) begin
        hcnt <= '0;
        vcnt <= (vcnt == CW'(V_TOTAL - 1)) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  video_delay_line #(
    .W         (SYNC_BUNDLE_W),
    .DEPTH     (PIPE),
    .RESET_VAL (SYNC_RST)
  ) u_sync_dly (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .din   (dec_q),
    .dout  (sync_o)
  );

  assign blank       = sync_o.blank;
  assign de          = sync_o.de;
  assign hsync       = sync_o.hsync;
  assign vsync       = sync_o.vsync;
  assign line_start  = sync_o.line_start;
  assign frame_start = sync_o.frame_start;

endmodule
